// File: rtl/ifq_line_fetch.sv
// Instruction-line responder: serves the aligned 4-word line holding a PC from a
// single-line buffer, refilling it word by word from memory on a miss.
module ifq_line_fetch #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cache_en,
    input  logic [ADDR_W-1:0]   pc,
    input  logic                branch_valid,
    output logic [4*DATA_W-1:0] dout,
    output logic                dout_valid,
    output logic                busy,
    output logic                mem_rd_req,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_rd_valid,
    input  logic [DATA_W-1:0]   mem_rd_data
);

    typedef enum logic [2:0] {IDLE, HIT, REQ, WAIT, RESP, DRAIN} state_t;

    state_t                 state, state_nxt;
    logic [ADDR_W-5:0]      line_tag;
    logic                   line_valid;
    logic [3:0][DATA_W-1:0] line_buf;
    logic [1:0]             word_cnt;
    logic                   hit;
    logic                   pc_unused;

    assign pc_unused = ^pc[3:0];
    assign hit       = line_valid && (line_tag == pc[ADDR_W-1:4]);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (cache_en && !branch_valid) state_nxt = hit ? HIT : REQ;
            HIT:   state_nxt = IDLE;
            REQ:   state_nxt = branch_valid ? DRAIN : WAIT;
            WAIT: begin
                if (mem_rd_valid) begin
                    if (branch_valid)          state_nxt = IDLE;
                    else if (word_cnt == 2'd3) state_nxt = RESP;
                    else                       state_nxt = REQ;
                end else if (branch_valid) begin
                    state_nxt = DRAIN;
                end
            end
            RESP:  state_nxt = IDLE;
            DRAIN: if (mem_rd_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The tag is captured at accept so the fill addresses come straight from it;
    // line_valid stays low until the whole line has landed.
    always_ff @(posedge clk) begin
        if (reset) begin
            line_tag   <= '0;
            line_valid <= 1'b0;
            line_buf   <= '0;
            word_cnt   <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (cache_en && !branch_valid && !hit) begin
                        line_tag   <= pc[ADDR_W-1:4];
                        line_valid <= 1'b0;
                        word_cnt   <= 2'd0;
                    end
                end
                WAIT: begin
                    if (mem_rd_valid && !branch_valid) begin
                        line_buf[word_cnt] <= mem_rd_data;
                        if (word_cnt != 2'd3) word_cnt <= word_cnt + 2'd1;
                    end
                end
                RESP:    line_valid <= 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        dout       = line_buf;
        busy       = (state != IDLE);
        mem_rd_req = (state == REQ);
        mem_addr   = (state == REQ) ? {line_tag, word_cnt, 2'b00} : '0;
        dout_valid = ((state == HIT) || (state == RESP)) && !branch_valid;
    end

endmodule

// File: tb/tb_ifq_line_fetch.sv
// Randomized and directed bench for ifq_line_fetch; expectations come from a
// line-level model (installed tag, fill schedule arithmetic, memory function).
module tb_ifq_line_fetch;

    logic         clk = 1'b0;
    logic         reset, cache_en, branch_valid, mem_rd_valid;
    logic [31:0]  pc, mem_rd_data, mem_addr;
    logic [127:0] dout;
    logic         dout_valid, busy, mem_rd_req;

    int vectors = 0;
    int miscompares = 0;

    bit          mvalid;
    logic [27:0] mtag;

    always #5 clk = ~clk;

    ifq_line_fetch #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .cache_en(cache_en), .pc(pc),
        .branch_valid(branch_valid), .dout(dout), .dout_valid(dout_valid),
        .busy(busy), .mem_rd_req(mem_rd_req), .mem_addr(mem_addr),
        .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data)
    );

    function automatic logic [31:0] memval(input logic [31:0] a);
        if (a[31:4] == 28'h10) return 32'hA0 + {30'd0, a[3:2]};
        return (a * 32'h9E3779B1) ^ 32'h00C0FFEE;
    endfunction

    function automatic logic [127:0] line_of(input logic [27:0] t);
        return {memval({t, 4'hC}), memval({t, 4'h8}), memval({t, 4'h4}), memval({t, 4'h0})};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request at cycle 0; memory answers lat cycles after each read request;
    // branch_valid pulses in cycle f (-1 none), reset pulses in cycle rst_c (-1 none).
    task automatic fetch(input logic [31:0] a, input int lat, input int f, input int rst_c);
        logic [27:0]  tag;
        logic [31:0]  addrs[$];
        logic [31:0]  pend_a;
        logic [127:0] dv_d;
        bit           hitx, pend, dv_exp;
        int           ret_c, ndv, dv_c, endc, big_r, nreq_exp;
        tag    = a[31:4];
        hitx   = mvalid && (mtag == tag);
        big_r  = 1 + 4 * (lat + 1);
        pend   = 0; ret_c = 0; pend_a = '0;
        ndv    = 0; dv_c = -1; dv_d = '0; endc = -1;

        @(negedge clk);
        cache_en = 1'b1; pc = a; branch_valid = (f == 0); mem_rd_valid = 1'b0;
        #1;
        chk("busy_c0", busy, 0);
        for (int c = 1; c < 200; c++) begin
            @(negedge clk);
            cache_en     = 1'b0;
            branch_valid = (c == f);
            reset        = (c == rst_c);
            mem_rd_valid = pend && (c == ret_c);
            mem_rd_data  = memval(pend_a);
            if (mem_rd_valid) pend = 0;
            #1;
            if (c == 1) chk("busy_c1", busy, (f != 0));
            if (mem_rd_req) begin
                addrs.push_back(mem_addr);
                pend = 1; pend_a = mem_addr; ret_c = c + lat;
            end
            if (dout_valid) begin
                ndv++; dv_c = c; dv_d = dout;
            end
            if (!busy) begin
                endc = c;
                break;
            end
        end
        branch_valid = 1'b0; mem_rd_valid = 1'b0; reset = 1'b0;

        chk("finished", (endc > 0), 1);
        if (rst_c > 0) begin
            chk("rst_end", endc, rst_c + 1);
            chk("rst_dv", ndv, 0);
            mvalid = 0; mtag = '0;
        end else if (f == 0) begin
            chk("drop_nreq", addrs.size(), 0);
            chk("drop_dv", ndv, 0);
            chk("drop_end", endc, 1);
        end else if (hitx) begin
            dv_exp = (f != 1);
            chk("hit_nreq", addrs.size(), 0);
            chk("hit_ndv", ndv, dv_exp);
            if (dv_exp) begin
                chk("hit_cyc", dv_c, 1);
                chk("hit_data", dv_d, line_of(tag));
            end
            chk("hit_end", endc, 2);
        end else begin
            nreq_exp = 0;
            for (int k = 0; k < 4; k++)
                if (f < 0 || 1 + k * (lat + 1) <= f) nreq_exp++;
            chk("miss_nreq", addrs.size(), nreq_exp);
            for (int k = 0; k < addrs.size() && k < 4; k++)
                chk("miss_addr", addrs[k], {tag, 4'(k * 4)});
            dv_exp = (f < 0 || f > big_r);
            chk("miss_ndv", ndv, dv_exp);
            if (dv_exp) begin
                chk("miss_cyc", dv_c, big_r);
                chk("miss_data", dv_d, line_of(tag));
                chk("miss_end", endc, big_r + 1);
            end
            mvalid = (f < 0 || f >= big_r);
            mtag   = tag;
        end
    endtask

    initial begin
        logic [31:0] lines[5];
        logic [31:0] a;
        int lat, f;
        lines[0] = 32'h100; lines[1] = 32'h110; lines[2] = 32'h200;
        lines[3] = 32'h300; lines[4] = 32'h500;
        reset = 1'b1; cache_en = 1'b1; pc = 32'h108; branch_valid = 1'b0;
        mem_rd_valid = 1'b0; mem_rd_data = '0;
        mvalid = 0; mtag = '0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("rst_outs", {dout_valid, busy, mem_rd_req}, 3'b000);
            chk("rst_addr", mem_addr, 0);
            chk("rst_dout", dout, 0);
        end
        @(negedge clk);
        reset = 1'b0; cache_en = 1'b0;
        #1;
        chk("rel_busy", busy, 0);

        fetch(32'h108, 1, -1, -1);             // miss, words 0xA0..0xA3
        fetch(32'h10C, 1, -1, -1);             // hit
        fetch(32'h110, 1, -1, -1);             // neighbouring line misses
        fetch(32'h200, 3, 7, -1);              // flush during second word's wait
        fetch(32'h200, 3, -1, -1);             // refills from word 0
        fetch(32'h110, 1, 0, -1);              // cache_en with flush is dropped
        fetch(32'h300, 2, 13, -1);             // flush in RESP, still installed
        fetch(32'h304, 2, -1, -1);             // so this hits
        fetch(32'h400, 2, -1, 5);              // reset while in WAIT

        @(negedge clk);
        mem_rd_valid = 1'b1; mem_rd_data = 32'hDEADBEEF;
        #1;
        chk("stray_busy", busy, 0);
        chk("stray_req", mem_rd_req, 0);
        @(negedge clk);
        mem_rd_valid = 1'b0;
        #1;
        chk("stray_busy2", busy, 0);
        chk("stray_dout", dout, 0);
        fetch(32'h108, 1, -1, -1);             // line was cleared by reset

        for (int n = 0; n < 40; n++) begin
            a   = lines[$urandom_range(0, 4)] | {28'd0, 4'($urandom_range(0, 15))};
            lat = $urandom_range(1, 4);
            f   = ($urandom_range(0, 9) < 6) ? -1 : $urandom_range(0, 2 + 4 * (lat + 1));
            fetch(a, lat, f, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
